// File: rtl/mannix_mem_pkg.sv
// Shared types for the Mannix memory farm read/write schedulers.
// Client indices, FSM state encoding and a one-hot helper.
package mannix_mem_pkg;

  localparam int N_CLI  = 6;
  localparam int ADDR_W = 19;
  localparam int IDX_W  = 3;

  typedef enum logic [IDX_W-1:0] {
    CLI_POOL     = 3'd0,
    CLI_CNN_WGT  = 3'd1,
    CLI_CNN_PIC  = 3'd2,
    CLI_FCC_BIAS = 3'd3,
    CLI_FCC_WGT  = 3'd4,
    CLI_FCC_PIC  = 3'd5
  } cli_idx_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_ISSUE,
    ST_DRAIN
  } rd_state_e;

  function automatic logic [N_CLI-1:0] idx_to_oh(input logic [IDX_W-1:0] idx);
    logic [N_CLI-1:0] oh;
    for (int i = 0; i < N_CLI; i++) oh[i] = (idx == IDX_W'(i));
    return oh;
  endfunction

endpackage

// File: rtl/mannix_mem_read_arb.sv
// Combinational client arbiter: fixed-with-favoured or round-robin from rr_ptr.
// Zero latency; no backpressure, the caller decides when to act on the winner.
module mannix_mem_read_arb
  import mannix_mem_pkg::*;
(
  input  logic [N_CLI-1:0] req,
  input  logic [4:0]       client_priority,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_CLI-1:0] win_oh,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_vld
);

  logic [IDX_W-1:0] fav;
  logic [IDX_W-1:0] slot;
  logic             found;

  always_comb begin
    fav     = client_priority[IDX_W-1:0];
    slot    = '0;
    found   = 1'b0;
    win_idx = '0;
    if (client_priority[4]) begin
      for (int k = 0; k < N_CLI; k++) begin
        slot = IDX_W'((int'(rr_ptr) + k) % N_CLI);
        if (!found && req[slot]) begin
          found   = 1'b1;
          win_idx = slot;
        end
      end
    end else if (int'(fav) < N_CLI && req[fav]) begin
      win_idx = fav;
    end else begin
      // favoured index 6/7 or idle favourite: lowest requester wins
      for (int k = N_CLI - 1; k >= 0; k--) begin
        if (req[IDX_W'(k)]) win_idx = IDX_W'(k);
      end
    end
  end

  assign win_vld = |req;
  assign win_oh  = win_vld ? idx_to_oh(win_idx) : '0;

endmodule

// File: rtl/mannix_mem_read_sched.sv
// Read scheduler: arbitrates six clients, issues a row burst, tags returned rows.
// Latency: 1 arb + 1 grant cycle, then 1 row/cycle; demux_busy stalls issue in place.
module mannix_mem_read_sched
  import mannix_mem_pkg::*;
#(
  parameter int LEN_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CLI-1:0]          cli_req,
  input  logic [N_CLI*ADDR_W-1:0]   cli_addr,
  input  logic [N_CLI*LEN_W-1:0]    cli_len,
  output logic [N_CLI-1:0]          cli_gnt,
  output logic [N_CLI-1:0]          cli_valid,
  output logic [N_CLI-1:0]          cli_last,
  input  logic [4:0]                client_priority,
  input  logic                      demux_busy,
  output logic                      sram_rd_en,
  output logic [ADDR_W-1:0]         sram_rd_addr,
  output logic                      sched_busy
);

  rd_state_e        state, nxt_state;
  logic [IDX_W-1:0] rr_ptr;
  logic [N_CLI-1:0] owner_oh;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0] len, cnt;
  logic [RD_LAT-1:0] vld_sr, last_sr;

  logic [N_CLI-1:0]  win_oh;
  logic [IDX_W-1:0]  win_idx;
  logic              win_vld;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic              arb_go, issue, last_issue;

  mannix_mem_read_arb u_arb (
    .req             (cli_req),
    .client_priority (client_priority),
    .rr_ptr          (rr_ptr),
    .win_oh          (win_oh),
    .win_idx         (win_idx),
    .win_vld         (win_vld)
  );

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < N_CLI; i++) begin
      if (win_idx == IDX_W'(i)) begin
        sel_addr = cli_addr[i*ADDR_W +: ADDR_W];
        sel_len  = cli_len[i*LEN_W +: LEN_W];
      end
    end
  end

  assign arb_go     = (state == ST_IDLE) && win_vld && !demux_busy;
  assign issue      = (state == ST_ISSUE) && !demux_busy;
  assign last_issue = issue && (cnt == len - LEN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      ST_IDLE:  if (arb_go) nxt_state = ST_GRANT;
      ST_GRANT: nxt_state = (len == '0) ? ST_IDLE : ST_ISSUE;
      ST_ISSUE: if (last_issue) nxt_state = ST_DRAIN;
      // the final row's last flag arrives after every earlier valid
      ST_DRAIN: if (last_sr[RD_LAT-1]) nxt_state = ST_IDLE;
      default:  nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      owner_oh <= '0;
      base     <= '0;
      len      <= '0;
      cnt      <= '0;
    end else if (arb_go) begin
      owner_oh <= win_oh;
      base     <= sel_addr;
      len      <= sel_len;
      cnt      <= '0;
      if (client_priority[4])
        rr_ptr <= (win_idx == IDX_W'(N_CLI - 1)) ? '0 : win_idx + IDX_W'(1);
    end else if (issue) begin
      cnt <= cnt + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr  <= '0;
      last_sr <= '0;
    end else begin
      vld_sr[0]  <= issue;
      last_sr[0] <= last_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
    end
  end

  always_comb begin
    cli_gnt      = (state == ST_GRANT) ? owner_oh : '0;
    cli_valid    = vld_sr[RD_LAT-1] ? owner_oh : '0;
    cli_last     = last_sr[RD_LAT-1] ? owner_oh : '0;
    sram_rd_en   = issue;
    sram_rd_addr = issue ? base + ADDR_W'(cnt) : '0;
    sched_busy   = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_mannix_mem_read_sched.sv
// Scoreboard bench for mannix_mem_read_sched: stimulus queues expected grants/rows/valids,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_mannix_mem_read_sched;
  import mannix_mem_pkg::*;

  localparam int LEN_W = 8;

  logic                    clk;
  logic                    rst;
  logic [N_CLI-1:0]        cli_req;
  logic [N_CLI*ADDR_W-1:0] cli_addr;
  logic [N_CLI*LEN_W-1:0]  cli_len;
  logic [N_CLI-1:0]        cli_gnt, cli_valid, cli_last;
  logic [4:0]              client_priority;
  logic                    demux_busy;
  logic                    sram_rd_en;
  logic [ADDR_W-1:0]       sram_rd_addr;
  logic                    sched_busy;

  mannix_mem_read_sched #(.LEN_W(LEN_W), .RD_LAT(1)) dut (
    .clk             (clk),
    .rst             (rst),
    .cli_req         (cli_req),
    .cli_addr        (cli_addr),
    .cli_len         (cli_len),
    .cli_gnt         (cli_gnt),
    .cli_valid       (cli_valid),
    .cli_last        (cli_last),
    .client_priority (client_priority),
    .demux_busy      (demux_busy),
    .sram_rd_en      (sram_rd_en),
    .sram_rd_addr    (sram_rd_addr),
    .sched_busy      (sched_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] len;
  } gexp_t;

  typedef struct packed {
    logic [2:0] idx;
    logic       last;
  } vexp_t;

  gexp_t             gnt_q[$];
  logic [ADDR_W-1:0] rd_q[$];
  vexp_t             val_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int tmo_cnt = 0;
  int left[N_CLI];
  bit end_req = 0;
  bit end_done = 0;

  function automatic logic [N_CLI-1:0] oh_of(input logic [2:0] i);
    logic [N_CLI-1:0] one;
    one = N_CLI'(1);
    return one << i;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  bit    after_last = 0;
  bit    after_zero = 0;
  gexp_t ge;
  vexp_t ve;
  logic [ADDR_W-1:0] ra;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_cli_out", 32'({cli_gnt, cli_valid, cli_last}), 32'd0);
      chk("rst_rd_out", 32'({sram_rd_en, sram_rd_addr, sched_busy}), 32'd0);
      gnt_q.delete();
      rd_q.delete();
      val_q.delete();
      after_last = 0;
      after_zero = 0;
    end else begin
      if (after_last) chk("busy_after_last", 32'(sched_busy), 32'd0);
      if (after_zero) chk("busy_after_len0", 32'(sched_busy), 32'd0);
      after_last = 0;
      after_zero = 0;
      if (demux_busy) chk("rd_en_in_stall", 32'(sram_rd_en), 32'd0);
      if (cli_gnt != '0) begin
        if (gnt_q.size() == 0) chk("unexpected_gnt", 32'(cli_gnt), 32'd0);
        else begin
          ge = gnt_q.pop_front();
          chk("gnt", 32'(cli_gnt), 32'(oh_of(ge.idx)));
          after_zero = (ge.len == 8'd0);
        end
      end
      if (sram_rd_en) begin
        if (rd_q.size() == 0) chk("unexpected_rd", 32'(sram_rd_addr), 32'hFFFF_FFFF);
        else begin
          ra = rd_q.pop_front();
          chk("rd_addr", 32'(sram_rd_addr), 32'(ra));
        end
      end
      if (cli_valid != '0) begin
        if (val_q.size() == 0) chk("unexpected_valid", 32'(cli_valid), 32'd0);
        else begin
          ve = val_q.pop_front();
          chk("valid", 32'(cli_valid), 32'(oh_of(ve.idx)));
          chk("last", 32'(cli_last), ve.last ? 32'(oh_of(ve.idx)) : 32'd0);
          if (ve.last) begin
            chk("busy_at_last", 32'(sched_busy), 32'd1);
            after_last = 1;
          end
        end
      end else if (cli_last != '0) begin
        chk("last_without_valid", 32'(cli_last), 32'd0);
      end
    end
    if (end_req && !end_done) begin
      chk("gnt_q_left", gnt_q.size(), 32'd0);
      chk("rd_q_left", rd_q.size(), 32'd0);
      chk("val_q_left", val_q.size(), 32'd0);
      chk("timeouts", tmo_cnt, 32'd0);
      end_done = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N_CLI; i++) begin
      if (cli_gnt[i] && left[i] > 0) left[i]--;
      cli_req[i] = (left[i] != 0);
    end
  endtask

  task automatic set_cli(input int idx, input logic [ADDR_W-1:0] a, input logic [7:0] l, input int n);
    cli_addr[idx*ADDR_W +: ADDR_W] = a;
    cli_len[idx*LEN_W +: LEN_W]    = l;
    left[idx]    = n;
    cli_req[idx] = (n != 0);
  endtask

  task automatic expect_burst(input int idx, input logic [ADDR_W-1:0] a, input logic [7:0] l);
    logic [ADDR_W-1:0] row;
    gnt_q.push_back('{idx: 3'(idx), len: l});
    row = a;
    for (int r = 0; r < int'(l); r++) begin
      rd_q.push_back(row);
      val_q.push_back('{idx: 3'(idx), last: (r == int'(l) - 1)});
      row = row + ADDR_W'(1);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int k = 0; k < budget; k++) begin
      step();
      if (cli_req == '0 && !sched_busy) return;
    end
    tmo_cnt++;
    $display("FAIL timeout %s: req=0x%0h busy=%0b expected idle", name, cli_req, sched_busy);
  endtask

  task automatic wait_gnt(input string name, input int budget);
    for (int k = 0; k < budget; k++) begin
      step();
      if (cli_gnt != '0) return;
    end
    tmo_cnt++;
    $display("FAIL timeout %s: no grant seen, expected one", name);
  endtask

  initial begin
    rst             = 1'b1;
    cli_req         = '0;
    cli_addr        = '0;
    cli_len         = '0;
    client_priority = 5'b00000;
    demux_busy      = 1'b0;
    for (int i = 0; i < N_CLI; i++) left[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();

    // single burst, fcc_pic
    set_cli(CLI_FCC_PIC, 19'h00100, 8'd4, 1);
    expect_burst(CLI_FCC_PIC, 19'h00100, 8'd4);
    wait_idle("single", 50);

    // fixed priority, favoured client 2
    client_priority = 5'b00010;
    set_cli(0, 19'h00010, 8'd2, 1);
    set_cli(2, 19'h00020, 8'd2, 1);
    set_cli(4, 19'h00040, 8'd2, 1);
    expect_burst(2, 19'h00020, 8'd2);
    expect_burst(0, 19'h00010, 8'd2);
    expect_burst(4, 19'h00040, 8'd2);
    wait_idle("fixed_fav2", 100);

    // fixed priority, no favoured client
    client_priority = 5'b00111;
    set_cli(0, 19'h00010, 8'd2, 1);
    set_cli(2, 19'h00020, 8'd2, 1);
    set_cli(4, 19'h00040, 8'd2, 1);
    expect_burst(0, 19'h00010, 8'd2);
    expect_burst(2, 19'h00020, 8'd2);
    expect_burst(4, 19'h00040, 8'd2);
    wait_idle("fixed_fav7", 100);

    // round robin, all six requesting, client 0 re-requests once
    client_priority = 5'b10000;
    for (int i = 0; i < N_CLI; i++) set_cli(i, ADDR_W'(32'h1000 + i * 16), 8'd1, (i == 0) ? 2 : 1);
    for (int i = 0; i < N_CLI; i++) expect_burst(i, ADDR_W'(32'h1000 + i * 16), 8'd1);
    expect_burst(0, 19'h01000, 8'd1);
    wait_idle("round_robin", 200);

    // write path owns SRAMs: no arbitration until it lets go, then a stall mid-burst
    client_priority = 5'b00111;
    demux_busy = 1'b1;
    set_cli(3, 19'h00200, 8'd8, 1);
    repeat (4) step();
    expect_burst(3, 19'h00200, 8'd8);
    demux_busy = 1'b0;
    wait_gnt("stall_gnt", 20);
    step();
    step();
    step();
    demux_busy = 1'b1;
    step();
    step();
    demux_busy = 1'b0;
    wait_idle("stall", 50);

    // address wrap
    set_cli(1, 19'h7FFFE, 8'd3, 1);
    gnt_q.push_back('{idx: 3'd1, len: 8'd3});
    rd_q.push_back(19'h7FFFE);
    rd_q.push_back(19'h7FFFF);
    rd_q.push_back(19'h00000);
    val_q.push_back('{idx: 3'd1, last: 1'b0});
    val_q.push_back('{idx: 3'd1, last: 1'b0});
    val_q.push_back('{idx: 3'd1, last: 1'b1});
    wait_idle("wrap", 50);

    // zero length
    set_cli(4, 19'h00777, 8'd0, 1);
    expect_burst(4, 19'h00777, 8'd0);
    wait_idle("len0", 50);
    step();

    // reset mid-burst at row 2 of 6
    set_cli(0, 19'h00300, 8'd6, 1);
    expect_burst(0, 19'h00300, 8'd6);
    begin
      bit hit;
      hit = 0;
      for (int k = 0; k < 50 && !hit; k++) begin
        step();
        if (sram_rd_en && sram_rd_addr == 19'h00302) hit = 1;
      end
      if (!hit) begin
        tmo_cnt++;
        $display("FAIL timeout mid_burst: row 0x302 never issued");
      end
    end
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // after reset rr_ptr is 0 again, so client 0 beats client 3
    client_priority = 5'b10000;
    set_cli(3, 19'h00500, 8'd2, 1);
    set_cli(0, 19'h00400, 8'd1, 1);
    expect_burst(0, 19'h00400, 8'd1);
    expect_burst(3, 19'h00500, 8'd2);
    wait_idle("post_reset_rr", 50);

    repeat (2) step();
    end_req = 1;
    for (int k = 0; k < 10 && !end_done; k++) step();
    if (!end_done) $display("FAIL end_check: monitor never completed final check");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + (end_done ? 0 : 1));
    $finish;
  end

endmodule
